// File: rtl/draw_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | draw_arb_pkg                                                         |
// | Shared types and default widths for the draw arbiter slice.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package draw_arb_pkg;

  localparam int XY_W  = 10;
  localparam int COL_W = 3;
  localparam int CNT_W = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Width of a binary index into n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/draw_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Combinational round-robin picker: first set req at index >= rr_ptr,  |
// | wrapping. With DRAW_ARB_PRIO0_EN defined, req[0] always wins.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] win_idx,
  output logic             valid
);

  int w_j;

  // Scan requesters starting at rr_ptr and keep the first one found.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    valid   = 1'b0;
    w_j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = int'(rr_ptr) + i;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!valid && req[w_j]) begin
        valid   = 1'b1;
        win_idx = IDX_W'(w_j);
      end
    end
`ifdef DRAW_ARB_PRIO0_EN
    // Level loader pre-empts the rotation so the level is fully drawn first.
    if (req[0]) begin
      valid   = 1'b1;
      win_idx = '0;
    end
`endif
    if (valid) gnt[win_idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/draw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | draw_arbiter                                                         |
// | Shares the VGA plot port among NREQ requesters. Each job latches the |
// | winner's x/y/colour and plots for DRAW_CYCLES cycles, then pulses    |
// | done. Optional macro: DRAW_ARB_PRIO0_EN (requester 0 has priority).  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module draw_arbiter #(
  parameter int NREQ        = 4,
  parameter int DRAW_CYCLES = 16,
  parameter int XY_W        = draw_arb_pkg::XY_W,
  parameter int COL_W       = draw_arb_pkg::COL_W
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*XY_W-1:0]            x_in,
  input  logic [NREQ*XY_W-1:0]            y_in,
  input  logic [NREQ*COL_W-1:0]           colour_in,
  output logic [NREQ-1:0]                 grant,
  output logic [NREQ-1:0]                 done,
  output logic                            plot,
  output logic [XY_W-1:0]                 x_out,
  output logic [XY_W-1:0]                 y_out,
  output logic [COL_W-1:0]                colour_out,
  output logic [draw_arb_pkg::CNT_W-1:0]  draw_count,
  output logic                            busy
);
  import draw_arb_pkg::*;

  localparam int              IDX_W  = idx_w(NREQ);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DRAW_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_TOP  = IDX_W'(NREQ - 1);

  state_t            r_state;
  state_t            w_next;
  logic [NREQ-1:0]   r_grant;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [NREQ-1:0]   w_pick_gnt;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_valid;
  logic [IDX_W-1:0]  w_ptr_next;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .gnt     (w_pick_gnt),
    .win_idx (w_pick_idx),
    .valid   (w_pick_valid)
  );

  assign w_ptr_next = (r_owner == C_TOP) ? '0 : r_owner + 1'b1;

  // State register; reset drops any job in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and port-facing strobes, decoded from the current state.
  always_comb begin
    w_next = r_state;
    grant  = '0;
    done   = '0;
    plot   = 1'b0;
    busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) w_next = S_DRAW;
      end
      S_DRAW: begin
        plot  = 1'b1;
        busy  = 1'b1;
        grant = r_grant;
        if (draw_count == C_LAST) w_next = S_ACK;
      end
      S_ACK: begin
        busy   = 1'b1;
        grant  = r_grant;
        done   = r_grant;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job latches, pixel counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      draw_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_grant    <= w_pick_gnt;
            r_owner    <= w_pick_idx;
            x_out      <= x_in[w_pick_idx*XY_W +: XY_W];
            y_out      <= y_in[w_pick_idx*XY_W +: XY_W];
            colour_out <= colour_in[w_pick_idx*COL_W +: COL_W];
            draw_count <= '0;
          end
        end
        S_DRAW: begin
          // Hold at the last offset so the count never wraps within a job.
          if (draw_count != C_LAST) draw_count <= draw_count + 1'b1;
        end
        S_ACK: begin
`ifdef DRAW_ARB_PRIO0_EN
          if (r_owner != '0) r_rr_ptr <= w_ptr_next;
`else
          r_rr_ptr <= w_ptr_next;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
